// File: rtl/instruction_memory_loader.sv
// Byte-stream program loader: packs little-endian words into instruction memory, verifies an
// XOR checksum and keeps the core in reset until a verified image is in place.
module instruction_memory_loader #(
    parameter int unsigned INSTRUCTION_MEMORY_SIZE = 64,
    parameter int unsigned START_ADDRESS           = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Start,
    input  logic [7:0]  InByte,
    input  logic        InValid,
    output logic        InReady,
    output logic        MemWriteEnable,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        CoreReset,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        header_hi;      // low count byte already taken
    logic [7:0]  count_lo;
    logic [15:0] word_count;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [7:0]  checksum;

    logic        transfer;
    logic        start_ok;
    logic [15:0] header_count;
    logic        last_data_byte;

    assign transfer       = InValid & InReady;
    assign start_ok       = Start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign header_count   = {InByte, count_lo};
    assign last_data_byte = (byte_idx == 2'd3) && (word_idx == word_count - 16'd1);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, otherwise an
    // unassigned path infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (Start) begin
                    state_next = S_HEADER;
                end
            end
            S_HEADER: begin
                if (transfer && header_hi) begin
                    if (header_count == 16'd0) begin
                        state_next = S_CHECK;
                    end else if ({16'd0, header_count} > INSTRUCTION_MEMORY_SIZE) begin
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (transfer && last_data_byte) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (transfer) begin
                    state_next = (InByte == checksum) ? S_DONE : S_ERROR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        InReady   = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        Error     = 1'b0;
        CoreReset = 1'b1;
        unique case (state)
            S_HEADER, S_DATA, S_CHECK: begin
                InReady = 1'b1;
                Busy    = 1'b1;
            end
            S_DONE: begin
                Done      = 1'b1;
                CoreReset = 1'b0;
            end
            S_ERROR: Error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            header_hi      <= 1'b0;
            count_lo       <= 8'd0;
            word_count     <= 16'd0;
            word_idx       <= 16'd0;
            byte_idx       <= 2'd0;
            word_buf       <= 24'd0;
            checksum       <= 8'd0;
            MemWriteEnable <= 1'b0;
            MemAddress     <= 32'(START_ADDRESS);
            MemWriteData   <= 32'd0;
        end else begin
            MemWriteEnable <= 1'b0;
            if (start_ok) begin
                header_hi  <= 1'b0;
                word_count <= 16'd0;
                word_idx   <= 16'd0;
                byte_idx   <= 2'd0;
                checksum   <= 8'd0;
            end else if (transfer && state == S_HEADER) begin
                if (!header_hi) begin
                    count_lo  <= InByte;
                    header_hi <= 1'b1;
                end else begin
                    word_count <= header_count;
                end
            end else if (transfer && state == S_DATA) begin
                checksum <= checksum ^ InByte;
                byte_idx <= byte_idx + 2'd1;
                unique case (byte_idx)
                    2'd0: word_buf[7:0]   <= InByte;
                    2'd1: word_buf[15:8]  <= InByte;
                    2'd2: word_buf[23:16] <= InByte;
                    2'd3: begin
                        MemWriteEnable <= 1'b1;
                        MemWriteData   <= {InByte, word_buf};
                        MemAddress     <= 32'(START_ADDRESS) + {14'd0, word_idx, 2'b00};
                        word_idx       <= word_idx + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Randomized scoreboard bench for instruction_memory_loader: a stimulus thread queues the
// expected memory writes, a negedge monitor pops and compares them as strobes appear.
module tb_instruction_memory_loader;

    localparam int unsigned SIZE  = 64;
    localparam int unsigned START = 0;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Start;
    logic [7:0]  InByte;
    logic        InValid;
    logic        InReady;
    logic        MemWriteEnable;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        CoreReset;
    logic        Busy;
    logic        Done;
    logic        Error;

    instruction_memory_loader #(
        .INSTRUCTION_MEMORY_SIZE(SIZE),
        .START_ADDRESS          (START)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .Start         (Start),
        .InByte        (InByte),
        .InValid       (InValid),
        .InReady       (InReady),
        .MemWriteEnable(MemWriteEnable),
        .MemAddress    (MemAddress),
        .MemWriteData  (MemWriteData),
        .CoreReset     (CoreReset),
        .Busy          (Busy),
        .Done          (Done),
        .Error         (Error)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         exp_wr;
    logic [31:0] img[$];
    int          checks = 0;
    int          errors = 0;
    bit          use_gaps = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET && MemWriteEnable) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", MemAddress, MemWriteData);
            end else begin
                exp_wr = exp_q.pop_front();
                check("write_addr", MemAddress, exp_wr.addr);
                check("write_data", MemWriteData, exp_wr.data);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int tries;
        if (use_gaps) begin
            repeat ($urandom_range(0, 3)) begin
                InValid = 1'b0;
                InByte  = 8'($urandom);
                Start   = 1'($urandom_range(0, 1));   // ignored while busy
                @(negedge CLK);
            end
            Start = 1'b0;
        end
        InValid = 1'b1;
        InByte  = b;
        tries   = 0;
        while (!InReady && tries < 100) begin
            @(negedge CLK);
            tries++;
        end
        if (!InReady) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: InReady stayed %b, required 1", InReady);
        end
        @(negedge CLK);
        InValid = 1'b0;
    endtask

    task automatic start_load();
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        check("start_busy", {31'd0, Busy}, 32'd1);
        check("start_flags", {30'd0, Done, Error}, 32'd0);
        check("start_core_reset", {31'd0, CoreReset}, 32'd1);
    endtask

    // Loads the first n words of img; force_zero sends 8'h00 instead of the true checksum.
    task automatic run_load(input int n, input bit force_zero);
        logic [7:0]  csum;
        logic [7:0]  sent;
        logic [31:0] w;
        bit          ok;
        csum = 8'h00;
        start_load();
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        if (n > int'(SIZE)) begin
            check("oversize_error", {31'd0, Error}, 32'd1);
            check("oversize_status", {28'd0, Done, Busy, InReady, CoreReset}, 32'd1);
            check("oversize_no_writes", 32'(exp_q.size()), 32'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = img[i];
            exp_q.push_back('{addr: START + 32'(4 * i), data: w});
            for (int k = 0; k < 4; k++) begin
                csum ^= 8'(w >> (8 * k));
                send_byte(8'(w >> (8 * k)));
            end
        end
        check("pre_check_core_reset", {31'd0, CoreReset}, 32'd1);
        check("pre_check_ready", {31'd0, InReady}, 32'd1);
        sent = force_zero ? 8'h00 : csum;
        ok   = (sent == csum);
        send_byte(sent);
        check("end_done", {31'd0, Done}, {31'd0, ok});
        check("end_error", {31'd0, Error}, {31'd0, !ok});
        check("end_core_reset", {31'd0, CoreReset}, {31'd0, !ok});
        check("end_idle_ports", {30'd0, Busy, InReady}, 32'd0);
        check("end_all_writes_seen", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready_we"}, {30'd0, InReady, MemWriteEnable}, 32'd0);
        check({tag, "_addr"}, MemAddress, START);
        check({tag, "_data"}, MemWriteData, 32'd0);
        check({tag, "_status"}, {28'd0, CoreReset, Busy, Done, Error}, 32'h8);
    endtask

    initial begin
        RESET   = 1'b1;
        Start   = 1'b0;
        InValid = 1'b0;
        InByte  = 8'h00;
        repeat (3) @(negedge CLK);
        check_reset_values("reset");
        RESET = 1'b0;
        @(negedge CLK);

        img = '{32'h00500093, 32'h00A00113};
        run_load(2, 1'b0);
        use_gaps = 1'b1;
        run_load(2, 1'b0);
        use_gaps = 1'b0;
        run_load(2, 1'b1);
        run_load(65, 1'b0);
        run_load(0, 1'b0);

        img.delete();
        for (int i = 0; i < int'(SIZE); i++) img.push_back($urandom);
        run_load(int'(SIZE), 1'b0);

        // Abort after the fifth byte (2 header + 3 data bytes): no word completed yet.
        start_load();
        send_byte(8'd3);
        send_byte(8'd0);
        for (int k = 0; k < 3; k++) send_byte(8'($urandom));
        RESET = 1'b1;
        @(negedge CLK);
        check_reset_values("midload_reset");
        RESET = 1'b0;
        @(negedge CLK);
        run_load(3, 1'b0);

        use_gaps = 1'b1;
        for (int t = 0; t < 6; t++) begin
            img.delete();
            for (int i = 0; i < 10; i++) img.push_back($urandom);
            run_load($urandom_range(1, 10), 1'($urandom_range(0, 1)));
        end
        use_gaps = 1'b0;

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
